// File: rtl/bw_mult_pkg.sv
// Shared helpers for the pipelined Baugh-Wooley multiplier: row grouping,
// signed-mode correction constant and parameter legality.
package bw_mult_pkg;

  localparam int BW_MIN_N = 4;
  localparam int BW_MAX_N = 32;

  typedef enum logic {
    BW_MODE_UNSIGNED = 1'b0,
    BW_MODE_SIGNED   = 1'b1
  } bw_mode_e;

  function automatic int rows_per_stage(input int n, input int stages);
    return (n + stages - 1) / stages;
  endfunction

  // 2^n + 2^(2n-1): folds the negative weights of the inverted terms back in
  function automatic logic [63:0] bw_correction(input int n);
    logic [63:0] c;
    c = 64'd0;
    c[n] = 1'b1;
    c[2*n-1] = 1'b1;
    return c;
  endfunction

  function automatic bit params_legal(input int n, input int stages);
    return (n >= BW_MIN_N) && (n <= BW_MAX_N) && (stages >= 1) && (stages <= n);
  endfunction

endpackage

// File: rtl/bw_pp_row.sv
// One shifted 2N-bit Baugh-Wooley partial-product row (combinational).
module bw_pp_row
  import bw_mult_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(2*N)
) (
  input  logic [N-1:0]   a,
  input  logic           b_bit,
  input  logic [IW-1:0]  row_index,
  input  logic           is_msb_row,
  input  logic           signed_mode,
  output logic [2*N-1:0] row
);

  logic [N-1:0] bits_s;

  // AND array with the sign-weight inversions applied in signed mode
  always_comb begin
    bits_s = {N{1'b0}};
    for (int j = 0; j < N; j++) begin
      bits_s[j] = (a[j] & b_bit) ^
                  (signed_mode & (is_msb_row ? (j != N-1) : (j == N-1)));
    end
  end

  assign row = {{N{1'b0}}, bits_s} << row_index;

endmodule

// File: rtl/bw_pipe_mult.sv
// Pipelined Baugh-Wooley multiplier: N rows grouped into STAGES adder/register
// slices with a valid/ready handshake and a global stall.
module bw_pipe_mult
  import bw_mult_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic           in_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic           out_signed
);

  localparam int             RPS       = rows_per_stage(N, STAGES);
  localparam int             IW        = $clog2(2*N);
  localparam logic [63:0]    CORR_FULL = bw_correction(N);
  localparam logic [2*N-1:0] CORR      = CORR_FULL[2*N-1:0];

  if (!params_legal(N, STAGES)) begin : g_param_check
    $error("bw_pipe_mult: illegal N/STAGES combination");
  end

  logic           advance_s;
  logic [N-1:0]   a_src_s     [STAGES];
  logic [N-1:0]   b_src_s     [STAGES];
  logic           mode_src_s  [STAGES];
  logic           valid_src_s [STAGES];
  logic [2*N-1:0] base_s      [STAGES];
  logic [2*N-1:0] next_sum_s  [STAGES];
  logic [2*N-1:0] row_s       [N];

  logic [N-1:0]   a_r     [STAGES];
  logic [N-1:0]   b_r     [STAGES];
  logic           mode_r  [STAGES];
  logic           valid_r [STAGES];
  logic [2*N-1:0] sum_r   [STAGES];

  assign advance_s  = ~valid_r[STAGES-1] | out_ready;
  assign in_ready   = advance_s;
  assign out_valid  = valid_r[STAGES-1];
  assign out_p      = sum_r[STAGES-1];
  assign out_signed = mode_r[STAGES-1];

  // Operand sources per slice: slice 0 takes the input port, later slices their predecessor
  always_comb begin
    a_src_s[0]     = in_a;
    b_src_s[0]     = in_b;
    mode_src_s[0]  = in_signed;
    valid_src_s[0] = in_valid;
    base_s[0]      = in_signed ? CORR : {2*N{1'b0}};
    for (int g = 1; g < STAGES; g++) begin
      a_src_s[g]     = a_r[g-1];
      b_src_s[g]     = b_r[g-1];
      mode_src_s[g]  = mode_r[g-1];
      valid_src_s[g] = valid_r[g-1];
      base_s[g]      = sum_r[g-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    bw_pp_row #(.N(N), .IW(IW)) u_row (
      .a           (a_src_s[i / RPS]),
      .b_bit       (b_src_s[i / RPS][i]),
      .row_index   (IW'(i)),
      .is_msb_row  ((i == N-1) ? 1'b1 : 1'b0),
      .signed_mode (mode_src_s[i / RPS]),
      .row         (row_s[i])
    );
  end

  // Each slice adds only the rows assigned to it onto the incoming running sum
  always_comb begin
    for (int g = 0; g < STAGES; g++) begin
      next_sum_s[g] = base_s[g];
      for (int i = 0; i < N; i++) begin
        next_sum_s[g] = next_sum_s[g] + (((i / RPS) == g) ? row_s[i] : {2*N{1'b0}});
      end
    end
  end

  // Slice registers; data only loads behind a valid so bubbles leave out_p untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < STAGES; g++) begin
        valid_r[g] <= 1'b0;
        mode_r[g]  <= 1'b0;
        sum_r[g]   <= {2*N{1'b0}};
        a_r[g]     <= {N{1'b0}};
        b_r[g]     <= {N{1'b0}};
      end
    end else if (advance_s) begin
      for (int g = 0; g < STAGES; g++) begin
        valid_r[g] <= valid_src_s[g];
        if (valid_src_s[g]) begin
          mode_r[g] <= mode_src_s[g];
          sum_r[g]  <= next_sum_s[g];
          a_r[g]    <= a_src_s[g];
          b_r[g]    <= b_src_s[g];
        end else begin
          mode_r[g] <= mode_r[g];
          sum_r[g]  <= sum_r[g];
          a_r[g]    <= a_r[g];
          b_r[g]    <= b_r[g];
        end
      end
    end else begin
      for (int g = 0; g < STAGES; g++) begin
        valid_r[g] <= valid_r[g];
        mode_r[g]  <= mode_r[g];
        sum_r[g]   <= sum_r[g];
        a_r[g]     <= a_r[g];
        b_r[g]     <= b_r[g];
      end
    end
  end

endmodule

// File: tb/tb_bw_pipe_mult.sv
// Directed and sweep bench for bw_pipe_mult: N=8/STAGES=4 handshake scenarios,
// exhaustive N=5 at STAGES 1/2/5, and a random N=32/STAGES=8 stream.
module tb_bw_pipe_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x, y, p;
    x = s ? {{24{a[7]}}, a} : {24'd0, a};
    y = s ? {{24{b[7]}}, b} : {24'd0, b};
    p = x * y;
    return p[15:0];
  endfunction

  function automatic logic [9:0] ref5(input logic [4:0] a, input logic [4:0] b, input logic s);
    int x, y, p;
    x = s ? {{27{a[4]}}, a} : {27'd0, a};
    y = s ? {{27{b[4]}}, b} : {27'd0, b};
    p = x * y;
    return p[9:0];
  endfunction

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y, p;
    x = s ? {{32{a[31]}}, a} : {32'd0, a};
    y = s ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return p;
  endfunction

  // ---------------- main N=8, STAGES=4 instance ----------------
  logic        m_in_valid, m_in_ready, m_in_signed;
  logic        m_out_valid, m_out_ready, m_out_signed;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_p;

  bw_pipe_mult #(.N(8), .STAGES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_a(m_a), .in_b(m_b), .in_signed(m_in_signed),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_p(m_p), .out_signed(m_out_signed)
  );

  // ---------------- N=5 sweep instances (STAGES 1, 2, 5) ----------------
  logic        v5, s5;
  logic [4:0]  a5, b5;
  logic        rdy5 [3];
  logic        ov5  [3];
  logic        os5  [3];
  logic [9:0]  p5   [3];
  logic [10:0] q5   [3][$];

  bw_pipe_mult #(.N(5), .STAGES(1)) dut5_s1 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5[0]),
    .in_a(a5), .in_b(b5), .in_signed(s5),
    .out_valid(ov5[0]), .out_ready(1'b1), .out_p(p5[0]), .out_signed(os5[0])
  );
  bw_pipe_mult #(.N(5), .STAGES(2)) dut5_s2 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5[1]),
    .in_a(a5), .in_b(b5), .in_signed(s5),
    .out_valid(ov5[1]), .out_ready(1'b1), .out_p(p5[1]), .out_signed(os5[1])
  );
  bw_pipe_mult #(.N(5), .STAGES(5)) dut5_s5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5[2]),
    .in_a(a5), .in_b(b5), .in_signed(s5),
    .out_valid(ov5[2]), .out_ready(1'b1), .out_p(p5[2]), .out_signed(os5[2])
  );

  // ---------------- N=32, STAGES=8 random instance ----------------
  logic        v32, s32, rdy32, ov32, os32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic [64:0] q32 [$];

  bw_pipe_mult #(.N(32), .STAGES(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32),
    .in_a(a32), .in_b(b32), .in_signed(s32),
    .out_valid(ov32), .out_ready(1'b1), .out_p(p32), .out_signed(os32)
  );

  // Scoreboards for the sweep instances: every emitted product must match the queue head
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ov5[k]) begin
        check($sformatf("n5_ready_s%0d", k), {63'd0, rdy5[k]}, 64'd1);
        if (q5[k].size() == 0) begin
          check($sformatf("n5_extra_s%0d", k), {63'd0, ov5[k]}, 64'd0);
        end else begin
          check($sformatf("n5_prod_s%0d", k), {53'd0, os5[k], p5[k]}, {53'd0, q5[k].pop_front()});
        end
      end
    end
    if (ov32) begin
      if (q32.size() == 0) begin
        check("n32_extra", {63'd0, ov32}, 64'd0);
      end else begin
        logic [64:0] e;
        e = q32.pop_front();
        check("n32_prod", p32, e[63:0]);
        check("n32_sgn", {63'd0, os32}, {63'd0, e[64]});
      end
    end
  end

  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] exp, input string tag);
    m_in_valid  = 1'b1;
    m_a         = a;
    m_b         = b;
    m_in_signed = s;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      m_in_valid = 1'b0;
      check($sformatf("%s_valid_c%0d", tag, k), {63'd0, m_out_valid}, {63'd0, (k == 4)});
    end
    check({tag, "_p"}, {48'd0, m_p}, {48'd0, exp});
    check({tag, "_sgn"}, {63'd0, m_out_signed}, {63'd0, s});
    @(negedge clk);
  endtask

  initial begin
    logic [16:0] bp_q [$];
    logic [16:0] e17;
    logic [15:0] held;
    bit          have_hold;
    bit          saw;
    int          sent, rcvd;

    rst = 1'b1;
    m_in_valid = 1'b0; m_a = 8'd0; m_b = 8'd0; m_in_signed = 1'b0; m_out_ready = 1'b1;
    v5 = 1'b0; s5 = 1'b0; a5 = 5'd0; b5 = 5'd0;
    v32 = 1'b0; s32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, m_out_valid}, 64'd0);
    check("rst_out_p", {48'd0, m_p}, 64'd0);
    check("rst_out_signed", {63'd0, m_out_signed}, 64'd0);
    check("rst_in_ready", {63'd0, m_in_ready}, 64'd1);

    // single transactions: latency and value
    send_one(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
    send_one(8'h7F, 8'h80, 1'b1, 16'hC080, "s_127xm128");
    send_one(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1x1");
    send_one(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255x255");
    send_one(8'h80, 8'h80, 1'b0, 16'h4000, "u_128x128");
    check("idle_p_stable", {48'd0, m_p}, 64'h4000);

    // back-to-back stream with alternating mode
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        m_in_valid = 1'b1; m_a = 8'hFF; m_b = 8'h02; m_in_signed = (c % 2 == 0);
      end else begin
        m_in_valid = 1'b0;
      end
      if (c >= 4) begin
        check($sformatf("b2b_valid_%0d", c - 4), {63'd0, m_out_valid}, 64'd1);
        check($sformatf("b2b_p_%0d", c - 4), {48'd0, m_p},
              ((c - 4) % 2 == 0) ? 64'hFFFE : 64'h01FE);
        check($sformatf("b2b_sgn_%0d", c - 4), {63'd0, m_out_signed},
              ((c - 4) % 2 == 0) ? 64'd1 : 64'd0);
      end else if (c >= 1) begin
        check($sformatf("b2b_idle_%0d", c), {63'd0, m_out_valid}, 64'd0);
      end
      @(negedge clk);
    end

    // backpressure: out_ready low for the first 6 cycles while offering 8 inputs
    sent = 0; rcvd = 0; have_hold = 1'b0; held = 16'd0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      m_out_ready = (c >= 6);
      if (sent < 8) begin
        m_in_valid = 1'b1; m_a = 8'hF0 + sent[7:0]; m_b = 8'h03; m_in_signed = sent[0];
      end else begin
        m_in_valid = 1'b0;
      end
      #1;
      if (m_out_valid && !m_out_ready) begin
        check("bp_in_ready", {63'd0, m_in_ready}, 64'd0);
        if (!have_hold) begin
          held = m_p; have_hold = 1'b1;
        end else begin
          check("bp_hold", {48'd0, m_p}, {48'd0, held});
        end
      end
      if (m_out_valid && m_out_ready) begin
        if (bp_q.size() == 0) begin
          check("bp_extra", {63'd0, m_out_valid}, 64'd0);
        end else begin
          e17 = bp_q.pop_front();
          check("bp_prod", {47'd0, m_out_signed, m_p}, {47'd0, e17});
        end
        rcvd++;
      end
      if (m_in_valid && m_in_ready) begin
        bp_q.push_back({m_in_signed, ref8(m_a, m_b, m_in_signed)});
        sent++;
      end
      @(negedge clk);
    end
    check("bp_stalled_seen", {63'd0, have_hold}, 64'd1);
    check("bp_count", rcvd, 64'd8);
    m_out_ready = 1'b1; m_in_valid = 1'b0;
    @(negedge clk);

    // reset with three transactions in flight
    for (int c = 0; c < 3; c++) begin
      m_in_valid = 1'b1; m_a = 8'h12 + c[7:0]; m_b = 8'h34; m_in_signed = c[0];
      @(negedge clk);
    end
    m_in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_valid", {63'd0, m_out_valid}, 64'd0);
    check("rstmid_p", {48'd0, m_p}, 64'd0);
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (m_out_valid) saw = 1'b1;
    end
    check("rstmid_flush", {63'd0, saw}, 64'd0);
    check("rstmid_p_idle", {48'd0, m_p}, 64'd0);

    // exhaustive N=5 sweep, both modes, three depths in parallel
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 32; a++) begin
        for (int b = 0; b < 32; b++) begin
          v5 = 1'b1; s5 = s[0]; a5 = a[4:0]; b5 = b[4:0];
          for (int k = 0; k < 3; k++) q5[k].push_back({s[0], ref5(a[4:0], b[4:0], s[0])});
          @(negedge clk);
        end
      end
    end
    v5 = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("n5_drain_s%0d", k), q5[k].size(), 64'd0);

    // random N=32 stream with a few corner operands first
    for (int n = 0; n < 10000; n++) begin
      v32 = 1'b1;
      s32 = $urandom_range(1, 0);
      case (n)
        0:       begin a32 = 32'h8000_0000; b32 = 32'h8000_0000; end
        1:       begin a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; end
        2:       begin a32 = 32'h7FFF_FFFF; b32 = 32'h8000_0000; end
        default: begin a32 = $urandom(); b32 = $urandom(); end
      endcase
      q32.push_back({s32, ref32(a32, b32, s32)});
      @(negedge clk);
    end
    v32 = 1'b0;
    repeat (12) @(negedge clk);
    check("n32_drain", q32.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bw_pipe_mult.md
Name: bw_pipe_mult

Overview:
Parametrised, pipelined Baugh-Wooley multiplier. It multiplies two N-bit operands and returns the full 2N-bit product. A per-transaction mode bit selects signed (two's complement) or unsigned operation. Valid/ready handshakes on both sides support backpressure. It is the drop-in successor to the fixed-width combinational multiplier in the datapath, for widths and clock rates where a single combinational array no longer closes timing.

Parameters:
N, 8, operand width in bits; legal range 4..32.
STAGES, 4, number of pipeline register stages; legal range 1..N. Partial-product rows are split evenly, ceil(N/STAGES) rows per stage, last stage takes the remainder.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand transfer request
in_ready  output  1  block can accept operands this cycle
in_a  input  N  multiplicand
in_b  input  N  multiplier
in_signed  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  product available
out_ready  input  1  consumer accepts product this cycle
out_p  output  2N  full-width product
out_signed  output  1  mode bit carried alongside the product

Behaviour:
- One clock domain. Reset is synchronous and active-high. Sample rst on rising clk only.
- Reset values: out_valid=0, out_p=0, out_signed=0. All internal stage valid bits=0. in_ready=1 in the first cycle after reset deasserts.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Stall rule:
  - advance = ~out_valid | out_ready.
  - in_ready = advance.
  - On advance, every stage register (data, mode, valid) loads from its predecessor.
  - Otherwise all stages hold. Bubbles are not compressed.
- Latency: exactly STAGES cycles from input transfer to out_valid, with out_ready held high. Throughput is one product per cycle.
- Row generation, row i (weight 2^i), bit j: pp[i][j] = a[j] & b[i].
- Signed mode (Baugh-Wooley):
  - Invert pp[i][N-1] for i<N-1.
  - Invert pp[N-1][j] for j<N-1.
  - pp[N-1][N-1] stays uninverted.
  - Add correction constant 2^N + 2^(2N-1).
- Unsigned mode: no inversions, correction constant 0.
- Accumulation:
  - Each stage adds its rows into a 2N-bit running sum.
  - Stage 1 seeds the sum with the correction constant.
  - Stage k also carries the unconsumed a, b and mode forward.
  - All sums are modulo 2^(2N); the final carry out is discarded.
- out_p is the exact product: signed result in two's complement, or the unsigned result. No truncation or rounding. Overflow is impossible at 2N bits.
- Boundaries:
  - Stalled pipeline: out_p and out_signed are stable while out_valid=1 and out_ready=0.
  - in_valid=0 while advancing inserts a bubble (stage valid=0). The data register is a don't-care, but out_p must not change while out_valid=0 following reset.
  - Simultaneous input and output transfer in the same cycle is legal when full.
  - Mode may change every transaction; each product uses its own in_signed.
  - rst mid-operation discards all in-flight transactions; no output is produced for them.
  - STAGES=1 degenerates to a single registered array with 1-cycle latency.

Decomposition:
- Package bw_mult_pkg holds:
  - function rows_per_stage(N,STAGES)
  - function bw_correction(N) returning the 2N-bit constant
  - parameter legality checks, as an elaboration-time error on an illegal N/STAGES
- Sub-module bw_pp_row: combinational generator of one shifted 2N-bit partial-product row. Ports: a, b_bit, row_index, is_msb_row, signed_mode.
- The top instantiates N rows via generate and groups them into STAGES adder/register slices.

Test Plan:
- N=8, STAGES=4, out_ready=1, signed:
  - a=0x80, b=0x80 -> out_p=0x4000 (-128 * -128 = 16384).
  - a=0x7F, b=0x80 -> 0xC080 (-16256).
  - a=0xFF, b=0x01 -> 0xFFFF.
  - Each product appears exactly 4 cycles after its transfer.
- Unsigned mode: a=0xFF, b=0xFF -> 0xFE01. a=0x80, b=0x80 -> 0x4000 with out_signed=0.
- Back-to-back stream:
  - Stimulus: 8 consecutive transactions alternating in_signed; a=0xFF, b=0x02 each time.
  - Required response: signed -> 0xFFFE, unsigned -> 0x01FE, in order, on 8 consecutive cycles.
- Backpressure:
  - Stimulus: hold out_ready=0 for 6 cycles while offering inputs.
  - Required response: in_ready drops once out_valid=1; out_p holds its first value; no transaction is lost or duplicated after release. Scoreboard count = 8.
- Reset mid-flight:
  - Stimulus: assert rst for 1 cycle with 3 transactions in the pipe.
  - Required response: out_valid=0 and out_p=0 next cycle; none of the 3 products ever emerge.
- Sweeps:
  - Exhaustive N=5 (STAGES=1, 2, 5), both modes, against a behavioural reference.
  - Random N=32, STAGES=8, 10k vectors.
